// File: rtl/io_pkg.sv
// Shared types and constants for the IO receive path.
package io_pkg;

  typedef logic [31:0] io_word_t;

  localparam int IO_RX_DEPTH_LOG2_DEF    = 10;
  localparam int IO_RX_HIGH_WATER_MARGIN = 16;

  function automatic int io_ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/io_rx_ram.sv
// Simple dual-port word RAM: synchronous write, registered read.
// Output register carries a synchronous reset so rd_data starts at 0.
module io_rx_ram
  import io_pkg::*;
#(
  parameter int ADDR_W = IO_RX_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  io_word_t          wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output io_word_t          rd_data
);

  io_word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/io_rx_ring.sv
// RX word ring between UART fetch and core IN path.
// Define IO_RX_DROP_COUNT_EN to build the saturating drop counter.
module io_rx_ring
  import io_pkg::*;
#(
  parameter  int DEPTH_LOG2   = IO_RX_DEPTH_LOG2_DEF,
  parameter  int INIT_POINTER = 0,
  parameter  int HIGH_WATER   = 2**DEPTH_LOG2 - IO_RX_HIGH_WATER_MARGIN,
  localparam int PTR_W        = io_ptr_w(DEPTH_LOG2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  input  logic [31:0]      wr_data,
  input  logic             rd_req,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [PTR_W-1:0] prod_pointer,
  output logic [PTR_W-1:0] cons_pointer,
  output logic [PTR_W-1:0] count,
  output logic             in_busy,
  output logic             almost_full,
  output logic             full,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  localparam logic [DEPTH_LOG2-1:0] INIT_IDX =
    INIT_POINTER[DEPTH_LOG2-1:0];
  localparam logic [PTR_W-1:0] INIT_PTR = {1'b0, INIT_IDX};

  logic wr_acc;
  logic wr_drop;
  logic rd_acc;

  assign count   = prod_pointer - cons_pointer;
  assign in_busy = (count == '0);
  // count never exceeds 2^DEPTH_LOG2, so the MSB alone marks full
  assign full        = count[PTR_W-1];
  assign almost_full = (int'(count) >= HIGH_WATER);

  assign wr_acc  = wr_valid & ~full;
  assign wr_drop = wr_valid & full;
  assign rd_acc  = rd_req & ~in_busy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prod_pointer <= INIT_PTR;
      cons_pointer <= INIT_PTR;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (wr_acc)  prod_pointer <= prod_pointer + PTR_W'(1);
      if (rd_acc)  cons_pointer <= cons_pointer + PTR_W'(1);
      if (wr_drop) overflow     <= 1'b1;
      rd_valid <= rd_acc;
    end
  end

  io_rx_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_acc),
    .wr_addr (prod_pointer[DEPTH_LOG2-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (cons_pointer[DEPTH_LOG2-1:0]),
    .rd_data (rd_data)
  );

`ifdef IO_RX_DROP_COUNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      drop_q <= '0;
    else if (wr_drop && drop_q != 16'hFFFF)
      drop_q <= drop_q + 16'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_io_rx_ring.sv
// Self-checking bench for io_rx_ring: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_io_rx_ring;

  localparam int DL    = 3;
  localparam int DEPTH = 2**DL;
  localparam int INIT  = 2;
  localparam int HW    = 6;
  localparam int PW    = DL + 1;

  typedef logic [31:0] word_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_valid = 1'b0;
  word_t         wr_data = '0;
  logic          rd_req = 1'b0;
  word_t         rd_data;
  logic          rd_valid;
  logic [PW-1:0] prod_pointer;
  logic [PW-1:0] cons_pointer;
  logic [PW-1:0] count;
  logic          in_busy;
  logic          almost_full;
  logic          full;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  io_rx_ring #(
    .DEPTH_LOG2   (DL),
    .INIT_POINTER (INIT),
    .HIGH_WATER   (HW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .prod_pointer (prod_pointer),
    .cons_pointer (cons_pointer),
    .count        (count),
    .in_busy      (in_busy),
    .almost_full  (almost_full),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model: FIFO of words plus totals since reset
  word_t q[$];
  int    wr_tot = 0;
  int    rd_tot = 0;
  logic  m_ovf  = 1'b0;
  int    m_drop = 0;
  logic  m_rv   = 1'b0;
  word_t m_rd   = '0;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int exp_drop;
`ifdef IO_RX_DROP_COUNT_EN
    exp_drop = m_drop;
`else
    exp_drop = 0;
`endif
    chk("prod_pointer", 32'(prod_pointer), (INIT + wr_tot) % (2*DEPTH));
    chk("cons_pointer", 32'(cons_pointer), (INIT + rd_tot) % (2*DEPTH));
    chk("count", 32'(count), q.size());
    chk("in_busy", 32'(in_busy), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= HW));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", rd_data, m_rd);
    chk("drop_count", 32'(drop_count), exp_drop);
  endtask

  task automatic cyc(input logic r, input logic wv, input word_t wd,
                     input logic rr);
    bit pre_full;
    bit pre_empty;
    rstn     = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    pre_full  = (q.size() == DEPTH);
    pre_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      wr_tot = 0;
      rd_tot = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_rv   = 1'b0;
      m_rd   = '0;
    end else begin
      m_rv = rr && !pre_empty;
      if (m_rv) begin
        m_rd = q.pop_front();
        rd_tot++;
      end
      if (wv) begin
        if (!pre_full) begin
          q.push_back(wd);
          wr_tot++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    check_all();
  endtask

  typedef struct {
    logic  wv;
    word_t wd;
    logic  rr;
    int    cnt;
    logic  rv;
    word_t rd;
    logic  busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 32'h11111111, 1'b0, 1, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 32'h22222222, 1'b0, 2, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 32'h33333333, 1'b0, 3, 1'b0, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 32'h44444444, 1'b0, 4, 1'b0, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 3, 1'b1, 32'h11111111, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 2, 1'b1, 32'h22222222, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h33333333, 1'b0};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 0, 1'b1, 32'h44444444, 1'b1};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h44444444, 1'b1};

    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("reset_prod", 32'(prod_pointer), INIT);
    chk("reset_busy", 32'(in_busy), 1);

    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].wv, tbl[i].wd, tbl[i].rr);
      chk("tbl_count", 32'(count), tbl[i].cnt);
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].rv));
      chk("tbl_rd_data", rd_data, tbl[i].rd);
      chk("tbl_in_busy", 32'(in_busy), 32'(tbl[i].busy));
    end

    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("empty_rd_cons", 32'(cons_pointer), (INIT + 4) % (2*DEPTH));

    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'b1, 32'hA0000000 + i, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_almost_full", 32'(almost_full), 1);
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("drop_overflow", 32'(overflow), 1);
    cyc(1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    chk("full_rw_data", rd_data, 32'hA0000000);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("drain_last", rd_data, 32'hA0000007);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 32'hB0000000 + i, i >= 3);
      if (i >= 3) chk("steady_count3", 32'(count), 3);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("stream_last", rd_data, 32'hB0000013);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 32'hC0000000 + i, 1'b0);
    chk("pre_reset_count", 32'(count), 5);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_cons", 32'(cons_pointer), INIT);
    chk("rst_rd_valid", 32'(rd_valid), 0);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 32'hD0000000 + i, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("inflight_rd_valid", 32'(rd_valid), 0);

    for (int i = 0; i < 600; i++) begin
      logic r;
      logic wv;
      logic rr;
      r  = ($urandom_range(0, 79) != 0);
      if (i < 300) begin
        wv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 2) == 0);
      end else begin
        wv = ($urandom_range(0, 2) == 0);
        rr = ($urandom_range(0, 3) != 0);
      end
      cyc(r, wv, $urandom, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
